fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the number of unacknowledged request cycles tolerated before error.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  downstream not ready; hold the current instruction.
REQ-006 SHALL have port branch_en  in  1  current instruction is a taken branch.
REQ-007 SHALL have port jump_en  in  1  current instruction is j/jal.
REQ-008 SHALL have port jump_reg_en  in  1  current instruction is jr/jalr.
REQ-009 SHALL have port rs_data  in  32  register target for jump_reg_en.
REQ-010 SHALL have port imem_req  out  1  instruction memory read request.
REQ-011 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-012 SHALL have port imem_ack  in  1  imem_rdata valid this cycle.
REQ-013 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-014 SHALL have port pc  out  32  address of the presented instruction.
REQ-015 SHALL have port instr  out  32  presented instruction word.
REQ-016 SHALL have port instr_valid  out  1  pc/instr hold a valid instruction.
REQ-017 SHALL have port fetch_err  out  1  sticky fault flag.
REQ-018 SHALL have port instr_count  out  32  count of consumed instructions.

Function
REQ-019 SHALL implement states IDLE, FETCH, DECODE, ERROR; IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-020 In FETCH: imem_req=1; imem_addr stays stable until ack; ack latches pc<=imem_addr, instr<=imem_rdata, instr_valid<=1, and moves to DECODE.
REQ-021 imem_ack outside FETCH SHALL be ignored; at most one outstanding request.
REQ-022 In DECODE with stall=1: pc, instr, instr_valid, imem_req=0 all hold; redirect inputs ignored.
REQ-023 In DECODE with stall=0: the instruction is consumed; instr_count+1; instr_valid<=0; next fetch address loaded; state -> FETCH.
REQ-024 Next address priority: jump_reg_en -> rs_data; else jump_en -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_en -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4; no delay slot.
REQ-025 pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0); branch target arithmetic likewise wraps mod 2^32.
REQ-026 Selected next address with [1:0] != 0 SHALL set fetch_err and go to ERROR instead of FETCH; instr_count still increments.
REQ-027 TIMEOUT consecutive FETCH cycles without ack SHALL set fetch_err and go to ERROR on the next edge; an ack in the TIMEOUT-th cycle is accepted normally.
REQ-028 ERROR is terminal until reset: imem_req=0, instr_valid=0, other outputs hold.
REQ-029 instr_count SHALL wrap from 0xFFFF_FFFF to 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, imem_req=0, imem_addr=RESET_PC, pc=0, instr=0, instr_valid=0, fetch_err=0, instr_count=0, timeout counter=0.
REQ-031 Reset asserted mid-FETCH SHALL abandon the request; a later imem_ack SHALL have no effect.

Verification
REQ-032 Release reset, ack after 2 cycles with rdata 0x20080005, stall=0 -> imem_addr 0x0, pc=0x0, instr=0x20080005, instr_valid 1 for one cycle, next imem_addr 0x4, instr_count 1.
REQ-033 beq at pc 0x10, imm 0x0003, branch_en=1 -> next imem_addr 0x20; imm 0xFFFF -> 0x10.
REQ-034 j 0x08000040 at pc 0x100, jump_en=1 -> next imem_addr 0x100; jump_reg_en with rs_data 0x202 -> fetch_err=1, ERROR, imem_req 0.
REQ-035 stall=1 for 3 cycles in DECODE with branch_en toggling -> outputs frozen, instr_count unchanged; stall=0 -> redirect per REQ-024.
REQ-036 Withhold ack TIMEOUT cycles -> fetch_err=1 next edge; repeat with ack at cycle TIMEOUT -> normal DECODE, no error.
REQ-037 pc 0xFFFF_FFFC, no redirect -> next imem_addr 0x0; rst_n low mid-FETCH then late ack -> all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with branch/jump redirect and fetch timeout
//
// Purpose: fetches one instruction at a time from instruction memory, presents
// it downstream together with its address, and computes the next fetch address
// from the consumed instruction (sequential, branch, jump, or register jump).
// A misaligned next address or an unanswered request raises a sticky fault and
// parks the unit in a terminal error state until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               downstream not ready; hold the presented instruction
//   branch_en           presented instruction is a taken branch
//   jump_en             presented instruction is j/jal
//   jump_reg_en         presented instruction is jr/jalr (target in rs_data)
//   rs_data             register target for jump_reg_en
//   imem_req/imem_addr  instruction memory read request and address
//   imem_ack/imem_rdata read response strobe and instruction word
//   pc, instr           address and word of the presented instruction
//   instr_valid         pc/instr hold a valid instruction
//   fetch_err           sticky fault flag
//   instr_count         number of consumed instructions (wraps)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_en,
  input  logic        jump_en,
  input  logic        jump_reg_en,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t        state_q;
  logic          imem_req_q;
  logic [31:0]   imem_addr_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          instr_valid_q;
  logic          fetch_err_q;
  logic [31:0]   instr_count_q;
  logic [CW-1:0] tmo_q;

  logic [31:0]   pc_plus4;
  logic [31:0]   branch_off;
  logic [31:0]   next_addr_d;

  assign pc_plus4   = pc_q + 32'd4;
  // Sign-extended 16-bit word offset, scaled to bytes.
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Redirect priority: register jump, absolute jump, taken branch, sequential.
  always_comb begin
    next_addr_d = pc_plus4;
    if (jump_reg_en) begin
      next_addr_d = rs_data;
    end else if (jump_en) begin
      next_addr_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_en) begin
      next_addr_d = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      pc_q          <= 32'h0;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      instr_count_q <= 32'h0;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
          tmo_q      <= '0;
        end

        FETCH: begin
          // An ack on the last tolerated cycle still wins over the timeout.
          if (imem_ack) begin
            pc_q          <= imem_addr_q;
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            tmo_q         <= '0;
            state_q       <= DECODE;
          end else if (tmo_q == TMO_LAST) begin
            fetch_err_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= ERROR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        DECODE: begin
          if (!stall) begin
            instr_count_q <= instr_count_q + 32'd1;
            instr_valid_q <= 1'b0;
            // A misaligned target is never issued to memory.
            if (next_addr_d[1:0] != 2'b00) begin
              fetch_err_q <= 1'b1;
              imem_req_q  <= 1'b0;
              state_q     <= ERROR;
            end else begin
              imem_addr_q <= next_addr_d;
              imem_req_q  <= 1'b1;
              tmo_q       <= '0;
              state_q     <= FETCH;
            end
          end
        end

        ERROR: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_en;
  logic        jump_en;
  logic        jump_reg_en;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] instr_count;

  int checks;
  int errors;
  logic [31:0] exp_count;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branch_en  (branch_en),
    .jump_en    (jump_en),
    .jump_reg_en(jump_reg_en),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic        br;
    logic        j;
    logic        jr;
    logic [31:0] rs;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    branch_en   = 1'b0;
    jump_en     = 1'b0;
    jump_reg_en = 1'b0;
    rs_data     = 32'h0;
  endtask

  // Respond to the current request after 'delay' idle cycles.
  task automatic ack_after(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Consume the presented instruction with the given redirect inputs.
  task automatic consume(input logic br, input logic j, input logic jr, input logic [31:0] rs);
    stall       = 1'b0;
    branch_en   = br;
    jump_en     = j;
    jump_reg_en = jr;
    rs_data     = rs;
    tick();
    clear_redirect();
    exp_count = exp_count + 32'd1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_req"},    {31'h0, imem_req},    32'h0);
    check({tag, " imem_addr"},   imem_addr,            32'h0);
    check({tag, " pc"},          pc,                   32'h0);
    check({tag, " instr"},       instr,                32'h0);
    check({tag, " instr_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, " fetch_err"},   {31'h0, fetch_err},   32'h0);
    check({tag, " instr_count"}, instr_count,          32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = 32'h0;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_count  = 32'h0;
    rst_n      = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    clear_redirect();

    vecs[0] = '{32'h0000_0010, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0000_0020};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0000_0010};
    vecs[2] = '{32'h0000_0100, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0,      32'h0000_0100};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0000_0000};
    vecs[4] = '{32'h0000_0200, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h4000,   32'h0000_4000};
    vecs[5] = '{32'h3000_0000, 32'h0C00_0010, 1'b1, 1'b1, 1'b0, 32'h0,      32'h3000_0040};
    vecs[6] = '{32'h0000_0040, 32'h1000_0005, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0000_0044};
    vecs[7] = '{32'h0000_0000, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0,      32'hFFFF_FFFC};

    // Reset state
    tick();
    tick();
    check_reset_vals("reset");

    // First fetch after reset release
    rst_n = 1'b1;
    tick();
    check("first req",  {31'h0, imem_req}, 32'h1);
    check("first addr", imem_addr,         32'h0);
    ack_after(2, 32'h2008_0005);
    check("first pc",    pc,                   32'h0);
    check("first instr", instr,                32'h2008_0005);
    check("first valid", {31'h0, instr_valid}, 32'h1);
    check("decode req",  {31'h0, imem_req},    32'h0);
    consume(1'b0, 1'b0, 1'b0, 32'h0);
    check("after valid", {31'h0, instr_valid}, 32'h0);
    check("next addr",   imem_addr,            32'h4);
    check("count 1",     instr_count,          32'h1);

    // Redirect vectors: jr to the start pc, fetch the word, then apply redirect
    for (int v = 0; v < 8; v++) begin
      ack_after(0, 32'h0000_0008);
      consume(1'b0, 1'b0, 1'b1, vecs[v].start_pc);
      check($sformatf("v%0d setup addr", v), imem_addr, vecs[v].start_pc);
      ack_after(1, vecs[v].word);
      check($sformatf("v%0d pc", v),    pc,    vecs[v].start_pc);
      check($sformatf("v%0d instr", v), instr, vecs[v].word);
      consume(vecs[v].br, vecs[v].j, vecs[v].jr, vecs[v].rs);
      check($sformatf("v%0d next addr", v), imem_addr,            vecs[v].exp_addr);
      check($sformatf("v%0d req", v),       {31'h0, imem_req},    32'h1);
      check($sformatf("v%0d err", v),       {31'h0, fetch_err},   32'h0);
      check($sformatf("v%0d count", v),     instr_count,          exp_count);
    end

    // Stall holds everything while branch_en toggles; current fetch is 0xFFFFFFFC
    ack_after(0, 32'h1000_0003);
    for (int i = 0; i < 3; i++) begin
      stall     = 1'b1;
      branch_en = i[0];
      tick();
      check($sformatf("stall%0d pc", i),    pc,                   32'hFFFF_FFFC);
      check($sformatf("stall%0d instr", i), instr,                32'h1000_0003);
      check($sformatf("stall%0d valid", i), {31'h0, instr_valid}, 32'h1);
      check($sformatf("stall%0d req", i),   {31'h0, imem_req},    32'h0);
      check($sformatf("stall%0d count", i), instr_count,          exp_count);
    end
    consume(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall release addr", imem_addr,   32'h0000_000C);
    check("stall release cnt",  instr_count, exp_count);

    // Misaligned register jump goes to terminal error
    ack_after(0, 32'h0000_0008);
    consume(1'b0, 1'b0, 1'b1, 32'h0000_0202);
    check("misalign err",   {31'h0, fetch_err},   32'h1);
    check("misalign req",   {31'h0, imem_req},    32'h0);
    check("misalign valid", {31'h0, instr_valid}, 32'h0);
    check("misalign count", instr_count,          exp_count);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 1'b0;
    check("error hold err",   {31'h0, fetch_err},   32'h1);
    check("error hold req",   {31'h0, imem_req},    32'h0);
    check("error hold valid", {31'h0, instr_valid}, 32'h0);
    check("error hold pc",    pc,                   32'h0000_000C);
    check("error hold count", instr_count,          exp_count);

    // Timeout: TMO cycles without ack
    do_reset();
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    check("tmo pre err", {31'h0, fetch_err}, 32'h0);
    check("tmo pre req", {31'h0, imem_req},  32'h1);
    tick();
    check("tmo err", {31'h0, fetch_err}, 32'h1);
    check("tmo req", {31'h0, imem_req},  32'h0);

    // Ack on the last tolerated cycle is accepted
    do_reset();
    ack_after(int'(TMO) - 1, 32'h1234_5678);
    check("tmo edge err",   {31'h0, fetch_err},   32'h0);
    check("tmo edge valid", {31'h0, instr_valid}, 32'h1);
    check("tmo edge instr", instr,                32'h1234_5678);

    // Reset mid-fetch, then a late ack
    consume(1'b0, 1'b0, 1'b0, 32'h0);
    check("midfetch req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async rst");
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late ack valid", {31'h0, instr_valid}, 32'h0);
    check("late ack pc",    pc,                   32'h0);
    check("late ack instr", instr,                32'h0);
    check("late ack addr",  imem_addr,            32'h0);
    check("late ack req",   {31'h0, imem_req},    32'h1);
    check("late ack count", instr_count,          32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
